// File: rtl/matrix_mult_engine.sv
// -----------------------------------------------------------------------------
// matrix_mult_engine
//   DIMxDIM signed matrix multiplier (C = A*B) for the packed module bus.
//   Operands A and B are captured from in_bus into local registers. After start
//   the engine produces one element of C per cycle. Each element uses DIM
//   parallel multipliers feeding a full-precision adder tree.
//
//   Build option: MATMUL_SATURATE_EN
//     defined   - an out-of-range element clamps to the EW-bit signed limits
//     undefined - an out-of-range element keeps its low EW bits (wrap)
//   ovf behaves the same way in both builds.
//
// Ports
//   clk        in   1      rising-edge clock
//   RESET      in   1      synchronous active-high reset
//   in_bus     in   BUS_W  packed operand matrix, element (r,c) at (r*DIM+c)*EW
//   load_a     in   1      capture in_bus into A (IDLE only)
//   load_b     in   1      capture in_bus into B (IDLE only)
//   start      in   1      begin C = A*B (IDLE only)
//   busy       out  1      high in COMPUTE and DONE
//   done       out  1      one-cycle pulse when C is complete
//   out_valid  out  1      C valid, from done until the next accepted start
//   ovf        out  1      sticky: some element of the last result overflowed EW
//   out_bus    out  BUS_W  packed result C
//   dbgState   out  2      current FSM state (IDLE=0, COMPUTE=1, DONE=2)
//
// Handshake: start is a request that is accepted only on an edge where the
//   engine is IDLE (busy=0); loads sampled on the same edge land first.
//   Requests while busy=1 are dropped, never queued. Completion is signalled by
//   a single-cycle done; out_valid then qualifies out_bus until the next
//   accepted start.
// -----------------------------------------------------------------------------
module matrix_mult_engine #(
  parameter int DIM   = 4,
  parameter int EW    = 16,
  parameter int BUS_W = DIM * DIM * EW
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [BUS_W-1:0] in_bus,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic             ovf,
  output logic [BUS_W-1:0] out_bus,
  output logic [1:0]       dbgState
);

  localparam int ACC_W = 2 * EW + $clog2(DIM);
  localparam int IDX_W = $clog2(DIM * DIM);
  localparam int LAST  = DIM * DIM - 1;

  localparam logic signed [EW-1:0]    EL_MAX  = {1'b0, {(EW-1){1'b1}}};
  localparam logic signed [EW-1:0]    EL_MIN  = {1'b1, {(EW-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(EL_MAX);
  localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'(EL_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } stateT;

  stateT             state;
  logic [BUS_W-1:0]  aReg;
  logic [BUS_W-1:0]  bReg;
  logic [BUS_W-1:0]  cReg;
  logic [IDX_W-1:0]  idx;

  logic [IDX_W-1:0]        rowIdx;
  logic [IDX_W-1:0]        colIdx;
  logic signed [EW-1:0]    aEl;
  logic signed [EW-1:0]    bEl;
  logic signed [2*EW-1:0]  prod;
  logic signed [ACC_W-1:0] sum;
  logic                    sumOvf;
  logic [EW-1:0]           storeVal;

  assign rowIdx   = idx / IDX_W'(DIM);
  assign colIdx   = idx % IDX_W'(DIM);
  assign out_bus  = cReg;
  assign dbgState = state;

  // Dot product of row rowIdx of A with column colIdx of B. The accumulator
  // carries clog2(DIM) guard bits so the sum itself can never overflow.
  always_comb begin
    aEl  = '0;
    bEl  = '0;
    prod = '0;
    sum  = '0;
    for (int k = 0; k < DIM; k++) begin
      aEl  = aReg[(int'(rowIdx) * DIM + k) * EW +: EW];
      bEl  = bReg[(k * DIM + int'(colIdx)) * EW +: EW];
      prod = (2*EW)'(aEl) * (2*EW)'(bEl);
      sum  = sum + ACC_W'(prod);
    end
  end

  assign sumOvf = (sum > SUM_MAX) || (sum < SUM_MIN);

`ifdef MATMUL_SATURATE_EN
  assign storeVal = !sumOvf ? sum[EW-1:0] : (sum[ACC_W-1] ? EL_MIN : EL_MAX);
`else
  assign storeVal = sum[EW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      aReg      <= '0;
      bReg      <= '0;
      cReg      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_a) aReg <= in_bus;
          if (load_b) bReg <= in_bus;
          if (start) begin
            state     <= COMPUTE;
            idx       <= '0;
            busy      <= 1'b1;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        COMPUTE: begin
          cReg[int'(idx) * EW +: EW] <= storeVal;
          if (sumOvf) ovf <= 1'b1;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(LAST)) begin
            state     <= DONE;
            done      <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
